// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb -- register file with per-register scoreboard (pending) bits.
//
// Two combinational read ports with write-through bypass, one write port, a
// claim port that marks a register as having a result outstanding, and a
// flush that clears every outstanding mark. Register 0 is hard-wired to zero
// and can never be written or claimed. On reset every register i is preloaded
// with i*INIT_STEP (truncated to XLEN) and all pending marks are cleared.
//
// Parameters
//   XLEN       data width
//   NREG       number of registers (power of two, >= 4)
//   INIT_STEP  reset preload step
//   AW         address width, derived from NREG
//
// Ports
//   clk                   clock, all state changes on the rising edge
//   rst                   synchronous active-high reset
//   raddr1/raddr2         read addresses
//   rdata1/rdata2         read data (combinational, bypasses same-cycle write)
//   rbusy1/rbusy2         registered pending bit of the addressed register
//   reg_wr/waddr/wdata    write port; a write also clears the pending bit
//   claim_en/claim_addr   mark a register pending at the next edge
//   flush                 clear all pending bits at the next edge
//   pend_cnt              registered number of pending registers
// -----------------------------------------------------------------------------
module reg_file_sb #(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int INIT_STEP = 10,
   parameter int AW        = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   output logic            rbusy1,
   output logic            rbusy2,
   input  logic            reg_wr,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic            claim_en,
   input  logic [AW-1:0]   claim_addr,
   input  logic            flush,
   output logic [AW:0]     pend_cnt
);

   localparam int CW = AW + 1;

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pend_next;
   logic            write_ok;
   logic            claim_ok;
   logic            cnt_inc;
   logic            cnt_dec;

   // Reset value of register idx, computed modulo 2**XLEN.
   function automatic logic [XLEN-1:0] preload(input int idx);
      return XLEN'(idx) * XLEN'(INIT_STEP);
   endfunction

   // Address 0 is inert for both writes and claims.
   assign write_ok = reg_wr   && (waddr      != '0);
   assign claim_ok = claim_en && (claim_addr != '0);

   // Next pending vector: write clears, claim sets (so claim wins on the same
   // register), flush clears everything and overrides both.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would infer a latch.
      pend_next = pending;
      if (write_ok) pend_next[waddr]      = 1'b0;
      if (claim_ok) pend_next[claim_addr] = 1'b1;
      if (flush)    pend_next             = '0;
   end

   // Incremental count: +1 only when a clear bit becomes set, -1 only when a
   // set bit is cleared by a write that is not simultaneously re-claimed.
   assign cnt_inc = claim_ok && !pending[claim_addr];
   assign cnt_dec = write_ok && pending[waddr] &&
                    !(claim_ok && (claim_addr == waddr));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         // NOTE: the register array is reset on purpose -- the preload values
         // are architecturally visible, so this cannot map to a plain RAM.
         for (int i = 0; i < NREG; i++) regs[i] <= preload(i);
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         if (write_ok) regs[waddr] <= wdata;
         pending <= pend_next;
         if (flush) pend_cnt <= '0;
         else       pend_cnt <= pend_cnt + CW'(cnt_inc) - CW'(cnt_dec);
      end
   end

   // Read port 1: register 0 forced to zero, same-cycle write forwarded.
   always_comb begin
      rdata1 = regs[raddr1];
      if (write_ok && (waddr == raddr1)) rdata1 = wdata;
      if (raddr1 == '0)                  rdata1 = '0;
   end

   // Read port 2: identical behaviour.
   always_comb begin
      rdata2 = regs[raddr2];
      if (write_ok && (waddr == raddr2)) rdata2 = wdata;
      if (raddr2 == '0)                  rdata2 = '0;
   end

   // Busy flags show only the registered state; same-cycle claims and writes
   // become visible after the edge.
   assign rbusy1 = pending[raddr1];
   assign rbusy2 = pending[raddr2];

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb -- self-checking bench for reg_file_sb.
//
// dut  : default parameters (XLEN=32, NREG=32, INIT_STEP=10), checked every
//        cycle against a behavioural model plus directed literal checks.
// dut2 : XLEN=16, NREG=8, INIT_STEP=10000, exercises preload truncation and
//        the narrow pend_cnt width with directed literal checks.
// Inputs change 2 time units after the rising edge; the model compare runs
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main instance -----------------
   logic        rst, reg_wr, claim_en, flush;
   logic [4:0]  raddr1, raddr2, waddr, claim_addr;
   logic [31:0] wdata, rdata1, rdata2;
   logic        rbusy1, rbusy2;
   logic [5:0]  pend_cnt;

   reg_file_sb dut (
      .clk(clk), .rst(rst),
      .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2),
      .rbusy1(rbusy1), .rbusy2(rbusy2),
      .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .flush(flush), .pend_cnt(pend_cnt)
   );

   // ---------------- narrow instance -----------------
   logic        b_rst, b_reg_wr, b_claim_en, b_flush;
   logic [2:0]  b_raddr1, b_raddr2, b_waddr, b_claim_addr;
   logic [15:0] b_wdata, b_rdata1, b_rdata2;
   logic        b_rbusy1, b_rbusy2;
   logic [3:0]  b_pend_cnt;

   reg_file_sb #(.XLEN(16), .NREG(8), .INIT_STEP(10000)) dut2 (
      .clk(clk), .rst(b_rst),
      .raddr1(b_raddr1), .raddr2(b_raddr2),
      .rdata1(b_rdata1), .rdata2(b_rdata2),
      .rbusy1(b_rbusy1), .rbusy2(b_rbusy2),
      .reg_wr(b_reg_wr), .waddr(b_waddr), .wdata(b_wdata),
      .claim_en(b_claim_en), .claim_addr(b_claim_addr),
      .flush(b_flush), .pend_cnt(b_pend_cnt)
   );

   // ---------------- bookkeeping -----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=0x%0h required=0x%0h",
                  name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model (main instance) -----------------
   logic [31:0] m_regs [32];
   bit          m_pend [32];
   bit          model_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] <= 32'(i * 10);
            m_pend[i] <= 1'b0;
         end
         model_valid <= 1'b1;
      end else if (model_valid) begin
         if (reg_wr && waddr != 0) m_regs[waddr] <= wdata;
         if (flush) begin
            for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
         end else begin
            if (reg_wr && waddr != 0)         m_pend[waddr]      <= 1'b0;
            if (claim_en && claim_addr != 0)  m_pend[claim_addr] <= 1'b1;
         end
      end
   end

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 0)                         return 32'd0;
      if (reg_wr && waddr != 0 && waddr == a) return wdata;
      return m_regs[a];
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
      return c;
   endfunction

   always @(negedge clk) begin
      if (model_valid) begin
         check("model_rdata1",   rdata1,   model_read(raddr1));
         check("model_rdata2",   rdata2,   model_read(raddr2));
         check("model_rbusy1",   rbusy1,   m_pend[raddr1]);
         check("model_rbusy2",   rbusy2,   m_pend[raddr2]);
         check("model_pend_cnt", pend_cnt, 64'(model_count()));
      end
   end

   // ---------------- stimulus helpers -----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      rst = 1'b0; reg_wr = 1'b0; claim_en = 1'b0; flush = 1'b0;
   endtask

   task automatic b_idle();
      b_rst = 1'b0; b_reg_wr = 1'b0; b_claim_en = 1'b0; b_flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; reg_wr = 1'b0; claim_en = 1'b0; flush = 1'b0;
      raddr1 = '0; raddr2 = '0; waddr = '0; claim_addr = '0; wdata = '0;
      b_rst = 1'b1; b_reg_wr = 1'b0; b_claim_en = 1'b0; b_flush = 1'b0;
      b_raddr1 = '0; b_raddr2 = '0; b_waddr = '0; b_claim_addr = '0;
      b_wdata = '0;
      tick();

      // Reset preload visible combinationally.
      idle(); b_idle();
      raddr1 = 5'd5; raddr2 = 5'd31; #1;
      check("rst_x5",      rdata1,   32'd50);
      check("rst_x31",     rdata2,   32'd310);
      check("rst_busy1",   rbusy1,   1'b0);
      check("rst_busy2",   rbusy2,   1'b0);
      check("rst_cnt",     pend_cnt, 6'd0);

      // Write-through bypass, then persistence; writes to x0 ignored.
      reg_wr = 1'b1; waddr = 5'd7; wdata = 32'hDEADBEEF; raddr1 = 5'd7; #1;
      check("bypass_x7",   rdata1,   32'hDEADBEEF);
      tick(); idle(); #1;
      check("persist_x7",  rdata1,   32'hDEADBEEF);
      reg_wr = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; #1;
      check("x0_bypass",   rdata1,   32'd0);
      tick(); idle(); #1;
      check("x0_after",    rdata1,   32'd0);

      // Claims on consecutive cycles, then a write releases x3.
      claim_en = 1'b1; claim_addr = 5'd3; raddr1 = 5'd3; raddr2 = 5'd4; #1;
      check("claim_nobyp", rbusy1,   1'b0);
      tick(); claim_addr = 5'd4; #1;
      check("cnt_1",       pend_cnt, 6'd1);
      check("busy_x3",     rbusy1,   1'b1);
      tick(); idle(); #1;
      check("cnt_2",       pend_cnt, 6'd2);
      check("busy_x4",     rbusy2,   1'b1);
      reg_wr = 1'b1; waddr = 5'd3; wdata = 32'h333;
      tick(); idle(); #1;
      check("release_x3",  rbusy1,   1'b0);
      check("cnt_after_w", pend_cnt, 6'd1);
      check("data_x3",     rdata1,   32'h333);

      // Same-cycle claim and write to x9: data written, pending stays set.
      claim_en = 1'b1; claim_addr = 5'd9; reg_wr = 1'b1; waddr = 5'd9;
      wdata = 32'h55; raddr1 = 5'd9;
      tick(); idle(); #1;
      check("cw_x9_data",  rdata1,   32'h55);
      check("cw_x9_busy",  rbusy1,   1'b1);
      check("cw_x9_cnt",   pend_cnt, 6'd2);

      // Claim x10 while releasing x4: net zero.
      claim_en = 1'b1; claim_addr = 5'd10; reg_wr = 1'b1; waddr = 5'd4;
      wdata = 32'h44;
      tick(); idle(); #1;
      check("net0_cnt",    pend_cnt, 6'd2);
      // Re-claim of pending x9, then a claim of x0: no count change.
      claim_en = 1'b1; claim_addr = 5'd9;
      tick(); claim_addr = 5'd0; raddr1 = 5'd0;
      tick(); idle(); #1;
      check("reclaim_cnt", pend_cnt, 6'd2);
      check("x0_busy",     rbusy1,   1'b0);

      // Claim x1..x5 (x9, x10 already pending), then flush with a
      // concurrent claim of x6 and write of x2.
      for (int i = 1; i <= 5; i++) begin
         claim_en = 1'b1; claim_addr = 5'(i);
         tick();
      end
      idle(); #1;
      check("cnt_7",       pend_cnt, 6'd7);
      flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd6;
      reg_wr = 1'b1; waddr = 5'd2; wdata = 32'h77;
      tick(); idle(); raddr1 = 5'd2; raddr2 = 5'd6; #1;
      check("flush_cnt",   pend_cnt, 6'd0);
      check("flush_busy1", rbusy1,   1'b0);
      check("flush_busy2", rbusy2,   1'b0);
      check("flush_x2",    rdata1,   32'h77);

      // Mid-operation reset with writes and claims active.
      claim_en = 1'b1; claim_addr = 5'd11; reg_wr = 1'b1; waddr = 5'd13;
      wdata = 32'h1313;
      tick();
      rst = 1'b1; reg_wr = 1'b1; waddr = 5'd5; wdata = 32'hAAAA;
      claim_en = 1'b1; claim_addr = 5'd7;
      tick(); idle(); raddr1 = 5'd5; raddr2 = 5'd13; #1;
      check("mrst_x5",     rdata1,   32'd50);
      check("mrst_x13",    rdata2,   32'd130);
      check("mrst_cnt",    pend_cnt, 6'd0);
      // Sweep all registers; the model compare covers every address.
      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i); raddr2 = 5'(31 - i);
         tick();
      end
      raddr1 = 5'd7; #1;
      check("mrst_x7",     rdata1,   32'd70);

      // Narrow instance: fill the scoreboard, then reset mid-operation.
      b_raddr1 = 3'd7; b_raddr2 = 3'd6;
      for (int i = 1; i <= 7; i++) begin
         b_claim_en = 1'b1; b_claim_addr = 3'(i);
         tick();
      end
      b_idle();
      b_reg_wr = 1'b1; b_waddr = 3'd6; b_wdata = 16'hBEEF;
      b_claim_en = 1'b1; b_claim_addr = 3'd6;
      tick(); b_idle(); #1;
      check("n_cnt_7",     b_pend_cnt, 4'd7);
      check("n_x6_data",   b_rdata2,   16'hBEEF);
      check("n_x7_busy",   b_rbusy1,   1'b1);
      b_rst = 1'b1; b_reg_wr = 1'b1; b_waddr = 3'd7; b_wdata = 16'h1234;
      b_claim_en = 1'b1; b_claim_addr = 3'd1; b_flush = 1'b0;
      tick(); b_idle(); #1;
      check("n_x7_trunc",  b_rdata1,   16'd4464);
      check("n_x6_pre",    b_rdata2,   16'd60000);
      check("n_cnt_0",     b_pend_cnt, 4'd0);
      check("n_busy_0",    b_rbusy1,   1'b0);
      b_raddr1 = 3'd3; b_raddr2 = 3'd0; #1;
      check("n_x3_pre",    b_rdata1,   16'd30000);
      check("n_x0",        b_rdata2,   16'd0);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
